gen_caller: RTL and testbench

- Caller-side counterpart to the generator modules: launches one generator run with captured arguments, then consumes its output tuples over the generator's `_ready`/`_valid`/`_done` handshake.
- Buffers tuples in a small FIFO and re-presents them downstream on a ready/valid interface of the same shape.
- Signals end-of-stream to the downstream consumer once every tuple has been delivered.
- Used as the harness that attaches a generator (e.g. a range-style producer with three arguments and two outputs) to a consuming block or testbench.

---
 rtl/gen_caller.sv | 213 +++++++++++++++++++++
 tb/tb_gen_caller.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_caller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// gen_caller
//
// Launches one generator run with captured arguments. It then collects the
// generator's output tuples into a small FIFO and presents them to a downstream
// consumer. When every tuple has been delivered, it raises an end-of-stream level.
//
// Handshakes: a beat moves across an interface on a rising _clock edge where
// both valid and ready are high. On the generator side these are g_valid and
// g_ready. On the downstream side they are _valid and _ready. A valid holder
// keeps its data stable until that beat.
//
// Ports
//   _clock, _reset_n          clock (rising edge), async active-low reset
//   cmd_start, arg0..arg2     start pulse and run arguments (base, limit, step)
//   busy                      run in progress (LAUNCH/DRAIN/FLUSH)
//   g_start                   one-cycle start to the generator
//   g_base/g_limit/g_step     captured arguments, held for the whole run
//   g_ready/g_valid/g_done    generator tuple handshake and finish flag
//   g_out0/g_out1             generator tuple
//   _ready/_valid             downstream handshake
//   _out0/_out1               downstream tuple (FIFO head)
//   _done                     end-of-stream level, high while in DONE
//   count                     tuples accepted this run, saturating
//   checksum                  (GEN_CALLER_CHECKSUM_EN only) wrapping sum of
//                             g_out0 + g_out1 over accepted tuples
//   dbg_state                 current FSM state for observation
//
// Optional feature macro: GEN_CALLER_CHECKSUM_EN
// -----------------------------------------------------------------------------
module gen_caller #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             _clock,
   input  logic             _reset_n,
   input  logic             cmd_start,
   input  logic [WIDTH-1:0] arg0,
   input  logic [WIDTH-1:0] arg1,
   input  logic [WIDTH-1:0] arg2,
   output logic             busy,
   output logic             g_start,
   output logic [WIDTH-1:0] g_base,
   output logic [WIDTH-1:0] g_limit,
   output logic [WIDTH-1:0] g_step,
   output logic             g_ready,
   input  logic             g_valid,
   input  logic             g_done,
   input  logic [WIDTH-1:0] g_out0,
   input  logic [WIDTH-1:0] g_out1,
   input  logic             _ready,
   output logic             _valid,
   output logic [WIDTH-1:0] _out0,
   output logic [WIDTH-1:0] _out1,
   output logic             _done,
   output logic [CNT_W-1:0] count,
`ifdef GEN_CALLER_CHECKSUM_EN
   output logic [WIDTH-1:0] checksum,
`endif
   output logic [2:0]       dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_DRAIN  = 3'd2,
      S_FLUSH  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t state;

   // FIFO storage
   logic [WIDTH-1:0] mem0 [DEPTH];
   logic [WIDTH-1:0] mem1 [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      occ;
   logic [AW:0]      occ_next;

   logic push;
   logic pop;
   logic start_acc;

   // g_ready is high only in DRAIN, so this also restricts pushes to DRAIN
   // and to the DRAIN->FLUSH edge.
   assign push      = g_ready & g_valid;
   assign pop       = _valid & _ready;
   assign start_acc = cmd_start & ((state == S_IDLE) | (state == S_DONE));

   assign _valid    = (occ != '0);
   assign _out0     = mem0[rd_ptr];
   assign _out1     = mem1[rd_ptr];
   assign dbg_state = state;

   always_comb begin
      occ_next = occ;
      if (push && !pop) begin
         occ_next = occ + 1'b1;
      end else if (!push && pop) begin
         occ_next = occ - 1'b1;
      end
   end

   // FIFO. The contents are zeroed on reset so that the head reads 0. The
   // pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge _clock or negedge _reset_n) begin
      if (!_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem0[i] <= '0;
            mem1[i] <= '0;
         end
      end else if (start_acc) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            mem0[wr_ptr] <= g_out0;
            mem1[wr_ptr] <= g_out1;
            wr_ptr       <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         occ <= occ_next;
      end
   end

   // Control FSM with registered outputs. g_ready is computed from the
   // occupancy after this edge. This ensures a push can never land on a full FIFO.
   always_ff @(posedge _clock or negedge _reset_n) begin
      if (!_reset_n) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         g_start  <= 1'b0;
         g_ready  <= 1'b0;
         _done    <= 1'b0;
         g_base   <= '0;
         g_limit  <= '0;
         g_step   <= '0;
         count    <= '0;
`ifdef GEN_CALLER_CHECKSUM_EN
         checksum <= '0;
`endif
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (cmd_start) begin
                  g_base   <= arg0;
                  g_limit  <= arg1;
                  g_step   <= arg2;
                  count    <= '0;
`ifdef GEN_CALLER_CHECKSUM_EN
                  checksum <= '0;
`endif
                  _done    <= 1'b0;
                  busy     <= 1'b1;
                  g_start  <= 1'b1;
                  g_ready  <= 1'b0;
                  state    <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               // g_done is not looked at here. Any level left over from the
               // previous run is ignored.
               g_start <= 1'b0;
               g_ready <= (occ_next != OCC_FULL);
               state   <= S_DRAIN;
            end
            S_DRAIN: begin
               if (g_done) begin
                  g_ready <= 1'b0;
                  state   <= S_FLUSH;
               end else begin
                  g_ready <= (occ_next != OCC_FULL);
               end
            end
            S_FLUSH: begin
               g_ready <= 1'b0;
               if (occ == '0) begin
                  busy  <= 1'b0;
                  _done <= 1'b1;
                  state <= S_DONE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase

         // Pushes only occur in DRAIN, or on the edge that leaves it. They
         // therefore never coincide with the start-of-run clear above.
         if (push) begin
            if (count != '1) begin
               count <= count + 1'b1;
            end
`ifdef GEN_CALLER_CHECKSUM_EN
            checksum <= checksum + g_out0 + g_out1;
`endif
         end
      end
   end

endmodule

// File: tb/tb_gen_caller.sv
`timescale 1ns/1ps
module tb_gen_caller;

   localparam int W  = 32;
   localparam int D  = 4;
   localparam int CW = 16;

   // ---------------- clock / reset ----------------
   logic          _clock = 1'b0;
   logic          _reset_n = 1'b0;
   logic          cmd_start = 1'b0;
   logic [W-1:0]  arg0 = '0, arg1 = '0, arg2 = '0;
   logic          busy, g_start, g_ready, _valid, _done;
   logic [W-1:0]  g_base, g_limit, g_step, _out0, _out1;
   logic          g_valid, g_done;
   logic [W-1:0]  g_out0, g_out1;
   logic          _ready;
   logic [CW-1:0] count;
   logic [2:0]    dbg_state;
`ifdef GEN_CALLER_CHECKSUM_EN
   logic [W-1:0]  checksum;
`endif

   always #5 _clock = ~_clock;

   int cyc = 0;
   always @(posedge _clock) cyc <= cyc + 1;

   gen_caller #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
      ._clock(_clock), ._reset_n(_reset_n), .cmd_start(cmd_start),
      .arg0(arg0), .arg1(arg1), .arg2(arg2),
      .busy(busy), .g_start(g_start),
      .g_base(g_base), .g_limit(g_limit), .g_step(g_step),
      .g_ready(g_ready), .g_valid(g_valid), .g_done(g_done),
      .g_out0(g_out0), .g_out1(g_out1),
      ._ready(_ready), ._valid(_valid), ._out0(_out0), ._out1(_out1),
      ._done(_done), .count(count),
`ifdef GEN_CALLER_CHECKSUM_EN
      .checksum(checksum),
`endif
      .dbg_state(dbg_state)
   );

   // ---------------- check helper ----------------
   int tests_run = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [2*W-1:0] exp_q[$];
   int             exp_cnt;
   logic [W-1:0]   exp_sum;

   // ---------------- downstream sink ----------------
   int             ready_low_until = 0;
   bit             ready_rand = 0;
   int             valid_seen = 0;
   int             first_valid_cyc = -1;
   bit             prev_stall = 0;
   logic [2*W-1:0] prev_head = '0;

   initial begin
      _ready = 1'b0;
      forever begin
         @(negedge _clock);
         if (!_reset_n) begin
            _ready = 1'b0;
            prev_stall = 0;
            continue;
         end
         if (cyc < ready_low_until) _ready = 1'b0;
         else if (ready_rand)       _ready = ($urandom_range(0, 3) != 0);
         else                       _ready = 1'b1;
         if (prev_stall) begin
            check("hold_valid", 64'(_valid), 64'd1);
            check("hold_data", 64'({_out0, _out1}), 64'(prev_head));
         end
         if (_valid) begin
            valid_seen++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
         end
         prev_stall = _valid && !_ready;
         prev_head  = {_out0, _out1};
         if (_valid && _ready) begin
            if (exp_q.size() == 0) check("sb_underflow", 64'(exp_q.size() == 0), 64'd0);
            else                   check("tuple", 64'({_out0, _out1}), 64'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- range generator model ----------------
   int gen_phase = 0;
   int gv, gl, gs;
   int gap_left = 0;
   int gap_max = 0;
   bit same_edge = 0;
   bit will_xfer = 0;
   int done_cyc = -1;
   int first_xfer_cyc = -1;

   initial begin
      g_valid = 1'b0; g_done = 1'b0; g_out0 = '0; g_out1 = '0;
      forever begin
         @(negedge _clock);
         if (!_reset_n) begin
            g_valid = 1'b0; g_done = 1'b0; gen_phase = 0; will_xfer = 0;
            continue;
         end
         case (gen_phase)
            0: if (g_start) begin
                  gv = int'($signed(g_base));
                  gl = int'($signed(g_limit));
                  gs = int'($signed(g_step));
                  gen_phase = 1;
               end
            1: begin
                  // leave the old done high across the launch edge, then drop it
                  g_done = 1'b0;
                  gap_left = $urandom_range(0, gap_max);
                  gen_phase = 2;
               end
            default: begin
                  if (will_xfer) begin
                     gv += gs;
                     g_valid = 1'b0;
                     gap_left = $urandom_range(0, gap_max);
                     if (g_done) gen_phase = 0;
                  end
                  if (gen_phase == 2) begin
                     if (gv >= gl) begin
                        g_valid = 1'b0; g_done = 1'b1; done_cyc = cyc; gen_phase = 0;
                     end else if (gap_left > 0) begin
                        g_valid = 1'b0; gap_left--;
                     end else begin
                        g_valid = 1'b1; g_out0 = W'(gv); g_out1 = W'(gv);
                        if (same_edge && (gv + gs >= gl) && g_ready) begin
                           g_done = 1'b1; done_cyc = cyc;
                        end
                     end
                  end
               end
         endcase
         will_xfer = g_valid && g_ready;
         if (will_xfer && first_xfer_cyc < 0) first_xfer_cyc = cyc;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_run(input int b, input int l, input int s);
      int sum;
      exp_q.delete();
      exp_cnt = 0;
      sum = 0;
      for (int v = b; v < l; v += s) begin
         exp_q.push_back({W'(v), W'(v)});
         exp_cnt++;
         sum += 2 * v;
      end
      exp_sum = W'(sum);
      first_xfer_cyc = -1; first_valid_cyc = -1; valid_seen = 0; done_cyc = -1;
      @(negedge _clock);
      arg0 = W'(b); arg1 = W'(l); arg2 = W'(s); cmd_start = 1'b1;
      @(negedge _clock);
      cmd_start = 1'b0;
      arg0 = $urandom; arg1 = $urandom; arg2 = $urandom;
   endtask

   task automatic wait_done(input string tag);
      int t = 0;
      while (_done !== 1'b1 && t < 400) begin
         @(negedge _clock);
         t++;
      end
      check({tag, "_done"}, 64'(_done), 64'd1);
   endtask

   task automatic end_checks(input string tag);
      check({tag, "_count"}, 64'(count), 64'(exp_cnt));
      check({tag, "_all_delivered"}, 64'(exp_q.size()), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      if (exp_cnt > 0) check({tag, "_first_latency"}, 64'(first_valid_cyc - first_xfer_cyc), 64'd1);
`ifdef GEN_CALLER_CHECKSUM_EN
      check({tag, "_checksum"}, 64'(checksum), 64'(exp_sum));
`endif
   endtask

   // ---------------- directed + random sequence ----------------
   int done_seen;
   int t;

   initial begin
      repeat (2) @(negedge _clock);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_g_start", 64'(g_start), 64'd0);
      check("rst_g_ready", 64'(g_ready), 64'd0);
      check("rst_valid", 64'(_valid), 64'd0);
      check("rst_done", 64'(_done), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      _reset_n = 1'b1;

      // 1: (1,11,3) with ready held high
      start_run(1, 11, 3);
      check("t1_busy", 64'(busy), 64'd1);
      wait_done("t1");
      end_checks("t1");

      // 2: (0,10,2) with downstream blocked for 20 cycles
      ready_low_until = cyc + 20;
      start_run(0, 10, 2);
      repeat (14) @(negedge _clock);
      check("t2_full_count", 64'(count), 64'd4);
      check("t2_full_g_ready", 64'(g_ready), 64'd0);
      check("t2_full_valid", 64'(_valid), 64'd1);
      wait_done("t2");
      end_checks("t2");

      // 3: empty run
      start_run(5, 5, 1);
      wait_done("t3");
      done_seen = cyc;
      check("t3_done_latency", 64'(done_seen - done_cyc), 64'd2);
      check("t3_no_valid", 64'(valid_seen), 64'd0);
      end_checks("t3");

      // 4: last tuple together with done
      same_edge = 1; gap_max = 2;
      start_run(3, 20, 4);
      wait_done("t4");
      end_checks("t4");
      same_edge = 0; gap_max = 0;

      // 5: async reset mid-run with two tuples stored
      ready_low_until = cyc + 1000;
      start_run(0, 10, 2);
      t = 0;
      while (count != 2 && t < 50) begin
         @(negedge _clock);
         t++;
      end
      check("t5_two_stored", 64'(count), 64'd2);
      _reset_n = 1'b0;
      #1;
      check("t5_busy", 64'(busy), 64'd0);
      check("t5_g_ready", 64'(g_ready), 64'd0);
      check("t5_valid", 64'(_valid), 64'd0);
      check("t5_g_limit", 64'(g_limit), 64'd0);
      check("t5_g_step", 64'(g_step), 64'd0);
      check("t5_out", 64'({_out0, _out1}), 64'd0);
      check("t5_count", 64'(count), 64'd0);
      exp_q.delete();
      ready_low_until = 0;
      repeat (2) @(negedge _clock);
      _reset_n = 1'b1;
      start_run(0, 10, 2);
      wait_done("t5b");
      end_checks("t5b");

      // 6: cmd_start while busy is ignored
      gap_max = 1;
      start_run(2, 30, 5);
      t = 0;
      while (count < 2 && t < 50) begin
         @(negedge _clock);
         t++;
      end
      arg0 = 100; arg1 = 200; arg2 = 7; cmd_start = 1'b1;
      @(negedge _clock);
      cmd_start = 1'b0;
      check("t6_busy", 64'(busy), 64'd1);
      check("t6_g_base", 64'(g_base), 64'd2);
      check("t6_g_limit", 64'(g_limit), 64'd30);
      check("t6_g_step", 64'(g_step), 64'd5);
      wait_done("t6");
      end_checks("t6");

      // random runs
      ready_rand = 1;
      for (int r = 0; r < 6; r++) begin
         int b, l, s;
         b = $urandom_range(0, 50);
         l = b + $urandom_range(0, 40);
         s = $urandom_range(1, 7);
         gap_max = $urandom_range(0, 3);
         same_edge = 1'($urandom_range(0, 1));
         start_run(b, l, s);
         wait_done("rnd");
         end_checks("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout tests_run=%0d", tests_run);
      $fatal(1, "watchdog");
   end

endmodule
